// File: rtl/seq_add_sub_unit.sv
// Multi-cycle adder/subtractor: SLICE bits per clock through a ripple slice
// with a registered carry, valid/ready handshakes, flags and a running accumulator.
module seq_add_sub_unit #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   input  logic             acc_sel,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, state_nxt;
   logic             accept_c, last_c;
   logic [WIDTH-1:0] aop, bop, sum, acc;
   logic [WIDTH-1:0] aop_sel_c, bop_sel_c, sum_full_c;
   logic [SLICE:0]   slice_sum_c;
   logic             carry, sign_a, sign_b;
   logic [CW-1:0]    cnt;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and handshake decode
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      last_c    = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept_c  = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            if (cnt == LAST) begin
               last_c    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand selection on accept and one ripple slice of the running sum
   always_comb begin
      aop_sel_c = a;
      if (acc_sel) aop_sel_c = acc_clr ? '0 : acc;
      bop_sel_c = op ? ~b : b;
      slice_sum_c = (SLICE+1)'(aop[cnt*SLICE +: SLICE])
                  + (SLICE+1)'(bop[cnt*SLICE +: SLICE])
                  + (SLICE+1)'(carry);
      sum_full_c = sum;
      sum_full_c[cnt*SLICE +: SLICE] = slice_sum_c[SLICE-1:0];
   end

   // Datapath, accumulator, flags and registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         aop       <= '0;
         bop       <= '0;
         sum       <= '0;
         acc       <= '0;
         carry     <= 1'b0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         cnt       <= '0;
         result    <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else begin
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
         if (state == IDLE && acc_clr) acc <= '0;
         if (accept_c) begin
            aop    <= aop_sel_c;
            bop    <= bop_sel_c;
            carry  <= op;
            cnt    <= '0;
            sign_a <= aop_sel_c[WIDTH-1];
            sign_b <= bop_sel_c[WIDTH-1];
         end
         if (state == CALC) begin
            sum   <= sum_full_c;
            carry <= slice_sum_c[SLICE];
            cnt   <= cnt + CW'(1);
            if (last_c) begin
               result <= sum_full_c;
               acc    <= sum_full_c;
               cout   <= slice_sum_c[SLICE];
               ovf    <= (sign_a == sign_b) && (sum_full_c[WIDTH-1] != sign_a);
               zero   <= ~|sum_full_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_add_sub_unit.sv
// Directed self-checking bench for seq_add_sub_unit at WIDTH=8, SLICE=4.
module tb_seq_add_sub_unit;

   logic       clk = 1'b0;
   logic       rst, in_valid, in_ready, op, acc_sel, acc_clr;
   logic       out_valid, out_ready, cout, ovf, zero;
   logic [7:0] a, b, result;

   int pass_cnt  = 0;
   int total_cnt = 0;

   seq_add_sub_unit #(.WIDTH(8), .SLICE(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .acc_sel(acc_sel), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .cout(cout), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   // Present one operation, wait for the accept edge, then count cycles to out_valid
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic top,
                         input logic tsel, input logic tclr, output int lat);
      @(negedge clk);
      a = ta; b = tb_v; op = top; acc_sel = tsel; acc_clr = tclr; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; acc_sel = 1'b0; acc_clr = 1'b0;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   // Accept the pending result with a one-cycle out_ready pulse
   task automatic pop();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (result !== 8'h00) $display("FAIL reset_result got %h want 00", result); else pass_cnt++;
      total_cnt++; if ({cout, ovf, zero} !== 3'b000) $display("FAIL reset_flags got %b want 000", {cout, ovf, zero}); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_arith();
      logic [7:0] va [7];
      logic [7:0] vb [7];
      logic       vop [7];
      logic [7:0] vr [7];
      logic [2:0] vf [7];
      int lat;
      va[0]=8'h3C; vb[0]=8'h0F; vop[0]=0; vr[0]=8'h4B; vf[0]=3'b000;
      va[1]=8'h05; vb[1]=8'h07; vop[1]=1; vr[1]=8'hFE; vf[1]=3'b000;
      va[2]=8'h07; vb[2]=8'h05; vop[2]=1; vr[2]=8'h02; vf[2]=3'b100;
      va[3]=8'h7F; vb[3]=8'h01; vop[3]=0; vr[3]=8'h80; vf[3]=3'b010;
      va[4]=8'h80; vb[4]=8'h01; vop[4]=1; vr[4]=8'h7F; vf[4]=3'b110;
      va[5]=8'hFF; vb[5]=8'h01; vop[5]=0; vr[5]=8'h00; vf[5]=3'b101;
      va[6]=8'hA5; vb[6]=8'h5A; vop[6]=0; vr[6]=8'hFF; vf[6]=3'b000;
      for (int i = 0; i < 7; i++) begin
         run_op(va[i], vb[i], vop[i], 1'b0, 1'b0, lat);
         total_cnt++; if (lat != 2) $display("FAIL arith%0d_latency got %0d want 2", i, lat); else pass_cnt++;
         total_cnt++; if (result !== vr[i]) $display("FAIL arith%0d_result got %h want %h", i, result, vr[i]); else pass_cnt++;
         total_cnt++; if ({cout, ovf, zero} !== vf[i]) $display("FAIL arith%0d_flags got %b want %b", i, {cout, ovf, zero}, vf[i]); else pass_cnt++;
         pop();
         total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL arith%0d_release got rdy=%b vld=%b want 1/0", i, in_ready, out_valid); else pass_cnt++;
      end
   endtask

   task automatic test_acc_chain();
      int lat;
      run_op(8'hEE, 8'h05, 1'b0, 1'b1, 1'b1, lat);
      total_cnt++; if (lat != 2 || result !== 8'h05) $display("FAIL acc_clr_add got %h lat %0d want 05 lat 2", result, lat); else pass_cnt++;
      pop();
      run_op(8'hEE, 8'h03, 1'b0, 1'b1, 1'b0, lat);
      total_cnt++; if (lat != 2 || result !== 8'h08) $display("FAIL acc_add got %h lat %0d want 08 lat 2", result, lat); else pass_cnt++;
      pop();
      run_op(8'hEE, 8'h08, 1'b1, 1'b1, 1'b0, lat);
      total_cnt++; if (result !== 8'h00 || {cout, ovf, zero} !== 3'b101) $display("FAIL acc_sub got %h flags %b want 00 flags 101", result, {cout, ovf, zero}); else pass_cnt++;
      pop();
   endtask

   task automatic test_backpressure();
      int lat;
      run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0, lat);
      total_cnt++; if (result !== 8'h46) $display("FAIL bp_result got %h want 46", result); else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = (i % 2 == 0); a = 8'hFF; b = 8'hFF;
         @(posedge clk); #1;
         total_cnt++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h46)
            $display("FAIL bp_hold%0d got vld=%b rdy=%b res=%h want 1/0/46", i, out_valid, in_ready, result);
         else pass_cnt++;
      end
      in_valid = 1'b0;
      pop();
      total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_release got rdy=%b vld=%b want 1/0", in_ready, out_valid); else pass_cnt++;
      total_cnt++; if (result !== 8'h46) $display("FAIL bp_idle_hold got %h want 46", result); else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      int lat;
      @(negedge clk);
      a = 8'h01; b = 8'h01; op = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL abort_calc_busy got %b want 0", in_ready); else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL abort_idle got rdy=%b vld=%b want 1/0", in_ready, out_valid); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL abort_no_result got %b want 0", out_valid); else pass_cnt++;
      run_op(8'hEE, 8'h00, 1'b0, 1'b1, 1'b0, lat);
      total_cnt++; if (result !== 8'h00 || zero !== 1'b1) $display("FAIL abort_acc_cleared got %h z=%b want 00 z=1", result, zero); else pass_cnt++;
      pop();
      run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, lat);
      total_cnt++; if (lat != 2 || result !== 8'h02 || {cout, ovf, zero} !== 3'b000) $display("FAIL abort_recover got %h lat %0d want 02 lat 2", result, lat); else pass_cnt++;
      pop();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0;
      acc_sel = 1'b0; acc_clr = 1'b0; a = '0; b = '0;
      test_reset();
      test_arith();
      test_acc_chain();
      test_backpressure();
      test_reset_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
